// File: rtl/int_div_issue_if.sv
// Bundles the core-side request/writeback signals and the divider req/ack bus.
// slave is the issue unit's view; master is the view of whoever drives it.
interface int_div_issue_if #(
    parameter int data_width    = 32,
    parameter int num_regs      = 32,
    parameter int reg_sel_width = $clog2(num_regs)
);
    logic                     req;
    logic [1:0]               op;
    logic [reg_sel_width-1:0] rd_sel;
    logic [data_width-1:0]    a;
    logic [data_width-1:0]    b;
    logic                     busy;
    logic                     ack;
    logic [data_width-1:0]    result;
    logic [reg_sel_width-1:0] rd_sel_out;
    logic                     div_req;
    logic [data_width-1:0]    div_a;
    logic [data_width-1:0]    div_b;
    logic                     div_ack;
    logic [data_width-1:0]    div_quotient;
    logic [data_width-1:0]    div_remainder;

    modport slave (
        input  req, op, rd_sel, a, b, div_ack, div_quotient, div_remainder,
        output busy, ack, result, rd_sel_out, div_req, div_a, div_b
    );

    modport master (
        output req, op, rd_sel, a, b, div_ack, div_quotient, div_remainder,
        input  busy, ack, result, rd_sel_out, div_req, div_a, div_b
    );
endinterface

// File: rtl/int_div_issue.sv
// Issues RISC-V DIVU/DIV/REMU/REM ops to an unsigned iterative divider, applying
// sign fix-up on return and resolving divide-by-zero / signed overflow locally.
module int_div_issue #(
    parameter int data_width    = 32,
    parameter int num_regs      = 32,
    parameter int reg_sel_width = $clog2(num_regs)
) (
    input  logic           clk,
    input  logic           rst,
    int_div_issue_if.slave bus
);
    localparam logic [data_width-1:0] MOST_NEG = {1'b1, {(data_width-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_BYPASS
    } state_t;

    state_t                   r_state, w_state_next;
    logic [1:0]               r_op, w_op_next;
    logic [reg_sel_width-1:0] r_tag, w_tag_next;
    logic [data_width-1:0]    r_a, w_a_next;
    logic [data_width-1:0]    r_b, w_b_next;
    logic                     r_div_zero, w_div_zero_next;
    logic                     r_busy, w_busy_next;
    logic                     r_ack, w_ack_next;
    logic [data_width-1:0]    r_result, w_result_next;
    logic [reg_sel_width-1:0] r_rd_sel_out, w_rd_sel_out_next;
    logic                     r_div_req, w_div_req_next;
    logic [data_width-1:0]    r_div_a, w_div_a_next;
    logic [data_width-1:0]    r_div_b, w_div_b_next;

    logic                     w_in_zero;
    logic                     w_in_ovf;
    logic                     w_neg_a;
    logic                     w_neg_b;
    logic                     w_neg_res;
    logic [data_width-1:0]    w_mag_a;
    logic [data_width-1:0]    w_mag_b;
    logic [data_width-1:0]    w_div_sel;
    logic [data_width-1:0]    w_fixed;
    logic [data_width-1:0]    w_bypass_res;

    assign w_in_zero = (bus.b == '0);
    assign w_in_ovf  = bus.op[0] && (bus.a == MOST_NEG) && (bus.b == '1);

    // op[0] marks the signed variants; op[1] selects remainder over quotient.
    assign w_neg_a   = r_op[0] & r_a[data_width-1];
    assign w_neg_b   = r_op[0] & r_b[data_width-1];
    assign w_mag_a   = w_neg_a ? -r_a : r_a;
    assign w_mag_b   = w_neg_b ? -r_b : r_b;
    assign w_div_sel = r_op[1] ? bus.div_remainder : bus.div_quotient;
    assign w_neg_res = r_op[1] ? w_neg_a : (w_neg_a ^ w_neg_b);
    assign w_fixed   = w_neg_res ? -w_div_sel : w_div_sel;

    assign w_bypass_res = r_div_zero ? (r_op[1] ? r_a : '1)
                                     : (r_op[1] ? '0  : r_a);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_op_next         = r_op;
        w_tag_next        = r_tag;
        w_a_next          = r_a;
        w_b_next          = r_b;
        w_div_zero_next   = r_div_zero;
        w_busy_next       = r_busy;
        w_ack_next        = 1'b0;
        w_result_next     = r_result;
        w_rd_sel_out_next = r_rd_sel_out;
        w_div_req_next    = 1'b0;
        w_div_a_next      = r_div_a;
        w_div_b_next      = r_div_b;

        unique case (r_state)
            // DONE is the ack cycle; busy is already low so a new op may start here.
            S_IDLE, S_DONE: begin
                w_state_next = S_IDLE;
                if (bus.req) begin
                    w_op_next       = bus.op;
                    w_tag_next      = bus.rd_sel;
                    w_a_next        = bus.a;
                    w_b_next        = bus.b;
                    w_div_zero_next = w_in_zero;
                    w_busy_next     = 1'b1;
                    w_state_next    = (w_in_zero || w_in_ovf) ? S_BYPASS : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_div_req_next = 1'b1;
                w_div_a_next   = w_mag_a;
                w_div_b_next   = w_mag_b;
                w_state_next   = S_WAIT;
            end
            S_WAIT: begin
                if (bus.div_ack) begin
                    w_ack_next        = 1'b1;
                    w_result_next     = w_fixed;
                    w_rd_sel_out_next = r_tag;
                    w_busy_next       = 1'b0;
                    w_state_next      = S_DONE;
                end
            end
            S_BYPASS: begin
                w_ack_next        = 1'b1;
                w_result_next     = w_bypass_res;
                w_rd_sel_out_next = r_tag;
                w_busy_next       = 1'b0;
                w_state_next      = S_DONE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op         <= '0;
            r_tag        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_div_zero   <= 1'b0;
            r_busy       <= 1'b0;
            r_ack        <= 1'b0;
            r_result     <= '0;
            r_rd_sel_out <= '0;
            r_div_req    <= 1'b0;
            r_div_a      <= '0;
            r_div_b      <= '0;
        end else begin
            r_op         <= w_op_next;
            r_tag        <= w_tag_next;
            r_a          <= w_a_next;
            r_b          <= w_b_next;
            r_div_zero   <= w_div_zero_next;
            r_busy       <= w_busy_next;
            r_ack        <= w_ack_next;
            r_result     <= w_result_next;
            r_rd_sel_out <= w_rd_sel_out_next;
            r_div_req    <= w_div_req_next;
            r_div_a      <= w_div_a_next;
            r_div_b      <= w_div_b_next;
        end
    end

    assign bus.busy       = r_busy;
    assign bus.ack        = r_ack;
    assign bus.result     = r_result;
    assign bus.rd_sel_out = r_rd_sel_out;
    assign bus.div_req    = r_div_req;
    assign bus.div_a      = r_div_a;
    assign bus.div_b      = r_div_b;
endmodule
